enigma_stream_ctrl: RTL and testbench
=====================================

// Module: enigma_stream_ctrl
// PURPOSE
//  Streaming sequencer for the 4-box substitution cipher core. Accepts ASCII chars on a valid/ready
//  stream, presents each letter with the current 2-bit setting to the core and returns the result on
//  a registered output stream. Steps the setting per letter (rotor style) so sender and receiver stay
//  in lockstep from a shared start key. Sits between the message source/sink and the cipher core.
// PARAMETERS
//  STEP     1   setting increment (mod 4) applied on each ratchet wrap; 0 = fixed setting
//  RATCHET  1   letters per setting step, >=1
//  CNT_W    16  width of char_count
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      synchronous reset, active high
//  start           in   1      pulse: load key, begin message (honoured only in IDLE)
//  key             in   2      initial setting for the message
//  in_valid        in   1      input char valid
//  in_data         in   8      input ASCII char
//  in_last         in   1      input char is final char of message
//  in_ready        out  1      controller accepts input this cycle
//  out_valid       out  1      output char valid
//  out_data        out  8      output ASCII char
//  out_last        out  1      output char is final char of message
//  out_ready       in   1      sink accepts output this cycle
//  cipher_char     out  8      char to core (combinational from in_data)
//  cipher_setting  out  2      setting to core (= setting register)
//  cipher_result   in   8      core result (combinational, same cycle)
//  busy            out  1      state != IDLE
//  done            out  1      one-cycle pulse at message completion
//  char_count      out  CNT_W  letters enciphered this message, saturating
// BEHAVIOUR
//  - Reset: state=IDLE; setting=0, ratchet=0; out_valid/out_data/out_last/done/char_count=0; in_ready=0.
//  - Letter = 0x41..0x5A. Accept = in_valid & in_ready.
//  - in_ready = (state==RUN) & (~out_valid | out_ready): 1 char/cycle throughput, no bubble.
//  - On accept: out_data <= letter ? cipher_result : in_data; out_last <= in_last; out_valid <= 1 next
//    cycle (latency 1). Output regs hold stable while out_valid & ~out_ready.
//  - out_valid clears on out handshake unless a new accept occurs the same cycle (reload wins).
//  - Stepping on accepted letter only: ratchet==RATCHET-1 -> ratchet=0, setting=(setting+STEP)%4;
//    else ratchet+1. Non-letters pass unchanged, no step, no count. Setting used is pre-step value.
//  - char_count +1 per accepted letter; saturates at all-ones.
//  FSM:
//   IDLE : start -> RUN; setting<=key, ratchet<=0, char_count<=0. in_ready=0.
//   RUN  : accept with in_last -> DRAIN. start ignored.
//   DRAIN: in_ready=0; out handshake with out_last=1 -> IDLE, done=1 for that next cycle only.
//  - start same cycle as done-return: ignored (state not yet IDLE); start in IDLE the next cycle.
//  - char_count holds after done until next start.
//  - rst mid-message: pending output discarded, all state per reset, no done pulse.
// CONFIGURATION
//  ENIGMA_LOWERCASE_EN defined: 0x61..0x7A folded to uppercase (minus 0x20) on cipher_char and
//   treated as letters (stepped, counted, enciphered). Undefined: lowercase = non-letter passthrough;
//   cipher_char = in_data unmodified.
// TESTING
//  1. rst held 2 cycles -> busy=0, in_ready=0, out_valid=0, char_count=0, done=0.
//  2. STEP=1,RATCHET=1, start key=2, send 'A','B','C' back-to-back, out_ready=1 -> cipher_setting
//     2,3,0 on accept cycles; out_data = core result one cycle later each; char_count=3.
//  3. Send 'A',' ','B' key=0 -> ' ' (0x20) out unchanged; settings 0,-,1; char_count=2.
//  4. out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data stable; release -> 1/cycle.
//  5. in_last on 4th char -> DRAIN, in_ready=0; done pulse 1 cycle after out_last handshake, busy=0;
//     start during RUN leaves setting unchanged.
//  6. rst mid-message with out_valid=1 -> next cycle out_valid=0, IDLE, char_count=0, no done.
//  7. ENIGMA_LOWERCASE_EN: in 'a' -> cipher_char=0x41, setting steps, counted; undefined -> 'a' out as-is.

Source files
------------

// File: rtl/enigma_stream_ctrl.sv
// Streaming sequencer for the 4-box substitution cipher core: valid/ready in, registered valid/ready out.
// Optional feature: define ENIGMA_LOWERCASE_EN to fold lowercase letters to uppercase and encipher them.
module enigma_stream_ctrl #(
  parameter int STEP    = 1,
  parameter int RATCHET = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       key,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [7:0]       cipher_char,
  output logic [1:0]       cipher_setting,
  input  logic [7:0]       cipher_result,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] char_count
);

  localparam int RW = (RATCHET > 1) ? $clog2(RATCHET) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_next;
  logic [1:0]      setting;
  logic [RW-1:0]   ratchet;
  logic            accept;
  logic            out_hs;
  logic            letter;

  function automatic logic is_letter(input logic [7:0] c);
`ifdef ENIGMA_LOWERCASE_EN
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
`else
    return (c >= 8'h41) && (c <= 8'h5A);
`endif
  endfunction

  function automatic logic [7:0] fold_case(input logic [7:0] c);
`ifdef ENIGMA_LOWERCASE_EN
    return ((c >= 8'h61) && (c <= 8'h7A)) ? c - 8'h20 : c;
`else
    return c;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  function automatic logic [1:0] step_setting(input logic [1:0] s);
    return s + 2'(STEP);
  endfunction

  assign cipher_char    = fold_case(in_data);
  assign cipher_setting = setting;
  assign letter         = is_letter(in_data);
  assign busy           = (state != IDLE);
  assign out_hs         = out_valid & out_ready;
  assign accept         = in_valid & in_ready;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        in_ready = ~out_valid | out_ready;
        if (in_valid && in_ready && in_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_hs && out_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      setting    <= 2'd0;
      ratchet    <= '0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_last   <= 1'b0;
      done       <= 1'b0;
      char_count <= '0;
    end else begin
      state <= state_next;
      done  <= (state == DRAIN) && out_hs && out_last;
      if ((state == IDLE) && start) begin
        setting    <= key;
        ratchet    <= '0;
        char_count <= '0;
      end
      // A fresh accept reloads the output register even when the old word leaves this cycle.
      if (accept) begin
        out_data  <= letter ? cipher_result : in_data;
        out_last  <= in_last;
        out_valid <= 1'b1;
        if (letter) begin
          char_count <= sat_inc(char_count);
          if (ratchet == RW'(RATCHET - 1)) begin
            ratchet <= '0;
            setting <= step_setting(setting);
          end else begin
            ratchet <= ratchet + 1'b1;
          end
        end
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enigma_stream_ctrl.sv
// Directed self-checking bench for enigma_stream_ctrl (STEP=1, RATCHET=1) with a behavioural cipher core.
module tb_enigma_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, out_ready;
  logic [1:0]  key;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, out_last, busy, done;
  logic [7:0]  out_data, cipher_char, cipher_result;
  logic [1:0]  cipher_setting;
  logic [15:0] char_count;
  logic [7:0]  held;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  enigma_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .cipher_char(cipher_char), .cipher_setting(cipher_setting), .cipher_result(cipher_result),
    .busy(busy), .done(done), .char_count(char_count)
  );

  // Stand-in core: depends on both char and setting, never maps a char to itself for the chars used.
  function automatic logic [7:0] core(input logic [7:0] c, input logic [1:0] s);
    int v;
    v = (int'(c) + 5 + 7 * int'(s)) % 26;
    return 8'(65 + v);
  endfunction

  always_comb cipher_result = core(cipher_char, cipher_setting);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = 2'd0; in_valid = 1'b0; in_data = 8'h00;
    in_last = 1'b0; out_ready = 1'b1;

    // reset held two cycles
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_char_count", 32'(char_count), 0);
    check("rst_done", 32'(done), 0);

    // key=2, 'A','B','C' back-to-back
    rst = 1'b0; start = 1'b1; key = 2'd2;
    tick();
    start = 1'b0;
    check("run_busy", 32'(busy), 1);
    in_valid = 1'b1; in_data = 8'h41; #1;
    check("a_in_ready", 32'(in_ready), 1);
    check("a_setting", 32'(cipher_setting), 2);
    check("a_cipher_char", 32'(cipher_char), 32'h41);
    tick();
    in_data = 8'h42; #1;
    check("a_out_valid", 32'(out_valid), 1);
    check("a_out_data", 32'(out_data), 32'(core(8'h41, 2'd2)));
    check("b_in_ready", 32'(in_ready), 1);
    check("b_setting", 32'(cipher_setting), 3);
    tick();
    in_data = 8'h43; #1;
    check("b_out_data", 32'(out_data), 32'(core(8'h42, 2'd3)));
    check("c_setting", 32'(cipher_setting), 0);
    tick();
    in_valid = 1'b0; #1;
    check("c_out_data", 32'(out_data), 32'(core(8'h43, 2'd0)));
    check("abc_char_count", 32'(char_count), 3);
    tick();
    check("idle_out_valid", 32'(out_valid), 0);

    // backpressure: 'D' held for three cycles, 'E' waiting
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44; #1;
    check("d_setting", 32'(cipher_setting), 1);
    tick();
    in_data = 8'h45;
    held = out_data;
    check("d_out_data", 32'(held), 32'(core(8'h44, 2'd1)));
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_data", 32'(out_data), 32'(core(8'h44, 2'd1)));
      check("bp_out_valid", 32'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1; start = 1'b1; key = 2'd0; #1;
    check("release_in_ready", 32'(in_ready), 1);
    check("e_setting", 32'(cipher_setting), 2);
    tick();
    start = 1'b0;
    in_data = 8'h46; in_last = 1'b1; #1;
    check("e_out_data", 32'(out_data), 32'(core(8'h45, 2'd2)));
    check("start_in_run_setting", 32'(cipher_setting), 3);
    tick();
    in_valid = 1'b0; in_last = 1'b0; start = 1'b1; key = 2'd1; #1;
    check("drain_in_ready", 32'(in_ready), 0);
    check("drain_busy", 32'(busy), 1);
    check("f_out_last", 32'(out_last), 1);
    check("f_out_data", 32'(out_data), 32'(core(8'h46, 2'd3)));
    check("drain_done", 32'(done), 0);
    tick();
    start = 1'b0; #1;
    check("done_pulse", 32'(done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_out_valid", 32'(out_valid), 0);
    check("done_char_count", 32'(char_count), 6);
    tick();
    check("done_one_cycle", 32'(done), 0);
    check("start_at_done_ignored", 32'(busy), 0);
    check("count_holds", 32'(char_count), 6);

    // key=0, 'A',' ','B', then 'a' as final char
    start = 1'b1; key = 2'd0;
    tick();
    start = 1'b0;
    check("k0_char_count", 32'(char_count), 0);
    in_valid = 1'b1; in_data = 8'h41; #1;
    check("k0_a_setting", 32'(cipher_setting), 0);
    tick();
    in_data = 8'h20; #1;
    check("k0_a_out", 32'(out_data), 32'(core(8'h41, 2'd0)));
    check("space_setting", 32'(cipher_setting), 1);
    tick();
    in_data = 8'h42; #1;
    check("space_out", 32'(out_data), 32'h20);
    check("k0_b_setting", 32'(cipher_setting), 1);
    tick();
    in_data = 8'h61; in_last = 1'b1; #1;
    check("k0_b_out", 32'(out_data), 32'(core(8'h42, 2'd1)));
    check("k0_char_count2", 32'(char_count), 2);
`ifdef ENIGMA_LOWERCASE_EN
    check("lc_cipher_char", 32'(cipher_char), 32'h41);
`else
    check("lc_cipher_char", 32'(cipher_char), 32'h61);
`endif
    tick();
    in_valid = 1'b0; in_last = 1'b0; #1;
`ifdef ENIGMA_LOWERCASE_EN
    check("lc_out", 32'(out_data), 32'(core(8'h41, 2'd2)));
    check("lc_char_count", 32'(char_count), 3);
    check("lc_setting", 32'(cipher_setting), 3);
`else
    check("lc_out", 32'(out_data), 32'h61);
    check("lc_char_count", 32'(char_count), 2);
    check("lc_setting", 32'(cipher_setting), 2);
`endif
    check("lc_out_last", 32'(out_last), 1);

    // reset while a final output is pending
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1; #1;
    check("mrst_out_valid", 32'(out_valid), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_char_count", 32'(char_count), 0);
    check("mrst_setting", 32'(cipher_setting), 0);
    check("mrst_done", 32'(done), 0);
    tick();
    check("mrst_no_done", 32'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no end of run, expected finish within 20000");
    $fatal(1);
  end

endmodule
